// File: rtl/lp_serdes_pkg.sv
// Shared definitions for the lp_tree serializer/deserializer link.
package lp_serdes_pkg;

  localparam int unsigned LP_SER_WIDTH = 16;
  localparam int unsigned LP_SER_CNT_W = $clog2(LP_SER_WIDTH);

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } bit_order_e;

endpackage

// File: rtl/lp_deser_counter.sv
// Free-running mod-WIDTH bit counter with SLIP hold, wrap strobe and the
// primed flag that gates the first (possibly partial) frame.
module lp_deser_counter
  import lp_serdes_pkg::*;
#(
  parameter int unsigned WIDTH      = LP_SER_WIDTH,
  parameter int unsigned INIT_COUNT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic slip,
  output logic wrap,
  output logic primed
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] INIT = CW'(INIT_COUNT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          primed_q, primed_d;

  always_comb begin
    wrap     = !slip && (cnt_q == LAST);
    cnt_d    = cnt_q;
    primed_d = primed_q | wrap;
    if (!slip) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= INIT;
      primed_q <= (INIT_COUNT == 0);
    end else begin
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
    end
  end

  assign primed = primed_q;

endmodule

// File: rtl/lp_tree_deserializer.sv
// Serial-to-parallel receiver: counter-framed WIDTH-bit words with a
// one-cycle VALID strobe and SLIP-based boundary realignment.
module lp_tree_deserializer #(
  parameter int unsigned WIDTH      = lp_serdes_pkg::LP_SER_WIDTH,
  parameter int unsigned MSB_FIRST  = 0,
  parameter int unsigned INIT_COUNT = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SERIAL_IN,
  input  logic             SLIP,
  output logic [WIDTH-1:0] PAR_OUT,
  output logic             VALID,
  inout  wire              VPWR,
  inout  wire              VGND
);

  localparam lp_serdes_pkg::bit_order_e ORDER =
    (MSB_FIRST != 0) ? lp_serdes_pkg::MSB_FIRST : lp_serdes_pkg::LSB_FIRST;

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] par_out_q, par_out_d;
  logic             valid_q, valid_d;
  logic             wrap;
  logic             primed;
  logic             unused_supply;

  assign unused_supply = VPWR ^ VGND;

  lp_deser_counter #(
    .WIDTH      (WIDTH),
    .INIT_COUNT (INIT_COUNT)
  ) u_counter (
    .clk    (CLK),
    .rst_n  (RESET),
    .slip   (SLIP),
    .wrap   (wrap),
    .primed (primed)
  );

  always_comb begin
    if (ORDER == lp_serdes_pkg::MSB_FIRST) begin
      shreg_d = {shreg_q[WIDTH-2:0], SERIAL_IN};
    end else begin
      shreg_d = {SERIAL_IN, shreg_q[WIDTH-1:1]};
    end
    par_out_d = par_out_q;
    valid_d   = 1'b0;
    // Capture the post-shift value so the bit sampled on this edge is included.
    if (wrap && primed) begin
      par_out_d = shreg_d;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      shreg_q   <= '0;
      par_out_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      par_out_q <= par_out_d;
      valid_q   <= valid_d;
    end
  end

  assign PAR_OUT = par_out_q;
  assign VALID   = valid_q;

endmodule

// File: tb/tb_lp_tree_deserializer.sv
// Randomized/directed bench for lp_tree_deserializer against a bit-history model.
module tb_lp_tree_deserializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin  [3];
  logic        slip [3];
  wire  [15:0] par_o [3];
  wire         val_o [3];
  wire         vpwr = 1'b1;
  wire         vgnd = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: dut0 LSB-first, dut1 MSB-first, dut2 LSB-first with INIT_COUNT=4.
  bit          hist [3][$];
  int          eff      [3];
  logic [15:0] exp_par  [3];
  logic        exp_val  [3];
  int          init_of  [3] = '{0, 0, 4};
  bit          msbf     [3] = '{1'b0, 1'b1, 1'b0};
  int          edge_n;

  always #5 clk = ~clk;

  lp_tree_deserializer #(.WIDTH(16), .MSB_FIRST(0), .INIT_COUNT(0)) u_lsb (
    .CLK(clk), .RESET(rst_n), .SERIAL_IN(sin[0]), .SLIP(slip[0]),
    .PAR_OUT(par_o[0]), .VALID(val_o[0]), .VPWR(vpwr), .VGND(vgnd));

  lp_tree_deserializer #(.WIDTH(16), .MSB_FIRST(1), .INIT_COUNT(0)) u_msb (
    .CLK(clk), .RESET(rst_n), .SERIAL_IN(sin[1]), .SLIP(slip[1]),
    .PAR_OUT(par_o[1]), .VALID(val_o[1]), .VPWR(vpwr), .VGND(vgnd));

  lp_tree_deserializer #(.WIDTH(16), .MSB_FIRST(0), .INIT_COUNT(4)) u_init (
    .CLK(clk), .RESET(rst_n), .SERIAL_IN(sin[2]), .SLIP(slip[2]),
    .PAR_OUT(par_o[2]), .VALID(val_o[2]), .VPWR(vpwr), .VGND(vgnd));

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      hist[d].delete();
      eff[d]     = 0;
      exp_par[d] = '0;
      exp_val[d] = 1'b0;
    end
    edge_n = 0;
  endtask

  // One clock edge; the model uses the inputs that were held across the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) begin
      edge_n++;
      for (int d = 0; d < 3; d++) begin
        hist[d].push_back(sin[d]);
        if (hist[d].size() > 16) void'(hist[d].pop_front());
        exp_val[d] = 1'b0;
        if (!slip[d]) begin
          eff[d]++;
          if (((eff[d] + init_of[d]) % 16 == 0) &&
              (init_of[d] == 0 || eff[d] + init_of[d] >= 32) && hist[d].size() == 16) begin
            exp_val[d] = 1'b1;
            for (int i = 0; i < 16; i++) begin
              if (msbf[d]) exp_par[d][15-i] = hist[d][i];
              else         exp_par[d][i]    = hist[d][i];
            end
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin sin[d] = 1'b0; slip[d] = 1'b0; end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      for (int d = 0; d < 3; d++) begin sin[d] = c[0]; slip[d] = 1'b0; end
      tick();
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (par_o[d] !== 16'h0000 || val_o[d] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset dut%0d cyc%0d: par=%h val=%b expected par=0000 val=0",
                   d, c, par_o[d], val_o[d]);
        end
      end
    end
  endtask

  task automatic test_lsb_frame();
    logic [15:0] w;
    do_reset();
    w = 16'hC5AF;
    for (int n = 1; n <= 24; n++) begin
      for (int d = 0; d < 3; d++) begin sin[d] = w[(n-1)%16]; slip[d] = 1'b0; end
      tick();
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (par_o[d] !== exp_par[d] || val_o[d] !== exp_val[d]) begin
          n_fail++;
          $display("FAIL lsb_frame dut%0d edge%0d: par=%h val=%b expected par=%h val=%b",
                   d, n, par_o[d], val_o[d], exp_par[d], exp_val[d]);
        end
      end
      n_checks++;
      if (par_o[0] !== ((n >= 16) ? 16'hC5AF : 16'h0000) || val_o[0] !== (n == 16)) begin
        n_fail++;
        $display("FAIL lsb_word edge%0d: par=%h val=%b expected par=%h val=%b",
                 n, par_o[0], val_o[0], (n >= 16) ? 16'hC5AF : 16'h0000, n == 16);
      end
    end
  endtask

  task automatic test_msb_frame();
    logic [15:0] w [2];
    w[0] = 16'hFF00;
    w[1] = 16'hF00F;
    do_reset();
    for (int n = 1; n <= 32; n++) begin
      for (int d = 0; d < 3; d++) begin
        sin[d]  = w[(n-1)/16][15 - (n-1)%16];
        slip[d] = 1'b0;
      end
      tick();
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (par_o[d] !== exp_par[d] || val_o[d] !== exp_val[d]) begin
          n_fail++;
          $display("FAIL msb_frame dut%0d edge%0d: par=%h val=%b expected par=%h val=%b",
                   d, n, par_o[d], val_o[d], exp_par[d], exp_val[d]);
        end
      end
      if (n == 16 || n == 32) begin
        n_checks++;
        if (par_o[1] !== w[n/16-1] || val_o[1] !== 1'b1) begin
          n_fail++;
          $display("FAIL msb_word edge%0d: par=%h val=%b expected par=%h val=1",
                   n, par_o[1], val_o[1], w[n/16-1]);
        end
      end
    end
  endtask

  task automatic test_partial_frame();
    logic [15:0] w;
    int first_valid;
    w = 16'hCC33;
    first_valid = 0;
    do_reset();
    for (int n = 1; n <= 60; n++) begin
      for (int d = 0; d < 3; d++) begin sin[d] = w[(n-1)%16]; slip[d] = 1'b0; end
      tick();
      n_checks++;
      if (par_o[2] !== exp_par[2] || val_o[2] !== exp_val[2]) begin
        n_fail++;
        $display("FAIL partial dut2 edge%0d: par=%h val=%b expected par=%h val=%b",
                 n, par_o[2], val_o[2], exp_par[2], exp_val[2]);
      end
      if (val_o[2] === 1'b1 && first_valid == 0) first_valid = n;
    end
    n_checks++;
    if (first_valid != 28) begin
      n_fail++;
      $display("FAIL partial_first_valid: edge=%0d expected edge=28", first_valid);
    end
  endtask

  task automatic test_slip();
    logic [15:0] w;
    logic [15:0] rot;
    w   = 16'h8811;
    rot = {w[0], w[15:1]};
    do_reset();
    for (int n = 1; n <= 50; n++) begin
      for (int d = 0; d < 3; d++) begin
        sin[d]  = w[(n-1)%16];
        slip[d] = (n == 5);
      end
      tick();
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (par_o[d] !== exp_par[d] || val_o[d] !== exp_val[d]) begin
          n_fail++;
          $display("FAIL slip dut%0d edge%0d: par=%h val=%b expected par=%h val=%b",
                   d, n, par_o[d], val_o[d], exp_par[d], exp_val[d]);
        end
      end
      if (n == 17 || n == 33 || n == 49) begin
        n_checks++;
        if (par_o[0] !== rot || val_o[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL slip_word edge%0d: par=%h val=%b expected par=%h val=1",
                   n, par_o[0], val_o[0], rot);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] w;
    w = 16'h3A5C;
    do_reset();
    for (int n = 1; n <= 24; n++) begin
      for (int d = 0; d < 3; d++) begin sin[d] = w[(n-1)%16]; slip[d] = 1'b0; end
      tick();
    end
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (par_o[d] !== 16'h0000 || val_o[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset_async dut%0d: par=%h val=%b expected par=0000 val=0",
                 d, par_o[d], val_o[d]);
      end
    end
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      for (int d = 0; d < 3; d++) begin sin[d] = 1'($urandom_range(1)); slip[d] = 1'b0; end
      tick();
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (par_o[d] !== exp_par[d] || val_o[d] !== exp_val[d] ||
            (d == 0 && val_o[0] !== (n == 16))) begin
          n_fail++;
          $display("FAIL mid_reset dut%0d edge%0d: par=%h val=%b expected par=%h val=%b",
                   d, n, par_o[d], val_o[d], exp_par[d], exp_val[d]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [6];
    words[0] = 16'hA815;
    words[1] = 16'hA995;
    for (int i = 2; i < 6; i++) words[i] = 16'($urandom);
    do_reset();
    for (int n = 1; n <= 96; n++) begin
      for (int d = 0; d < 2; d++) begin
        sin[d]  = msbf[d] ? words[(n-1)/16][15 - (n-1)%16] : words[(n-1)/16][(n-1)%16];
        slip[d] = 1'b0;
      end
      sin[2]  = 1'($urandom_range(1));
      slip[2] = ($urandom_range(7) == 0);
      tick();
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (par_o[d] !== exp_par[d] || val_o[d] !== exp_val[d]) begin
          n_fail++;
          $display("FAIL back_to_back dut%0d edge%0d: par=%h val=%b expected par=%h val=%b",
                   d, n, par_o[d], val_o[d], exp_par[d], exp_val[d]);
        end
      end
      if (n % 16 == 0) begin
        for (int d = 0; d < 2; d++) begin
          n_checks++;
          if (par_o[d] !== words[n/16-1] || val_o[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL loopback_word dut%0d edge%0d: par=%h val=%b expected par=%h val=1",
                     d, n, par_o[d], val_o[d], words[n/16-1]);
          end
        end
      end
    end
  endtask

  task automatic test_random_slip();
    do_reset();
    for (int n = 1; n <= 300; n++) begin
      for (int d = 0; d < 3; d++) begin
        sin[d]  = 1'($urandom_range(1));
        slip[d] = ($urandom_range(9) == 0);
      end
      tick();
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (par_o[d] !== exp_par[d] || val_o[d] !== exp_val[d]) begin
          n_fail++;
          $display("FAIL random_slip dut%0d edge%0d: par=%h val=%b expected par=%h val=%b",
                   d, n, par_o[d], val_o[d], exp_par[d], exp_val[d]);
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin sin[d] = 1'b0; slip[d] = 1'b0; end
    #2;
    test_reset();
    test_lsb_frame();
    test_msb_frame();
    test_partial_frame();
    test_slip();
    test_mid_reset();
    test_back_to_back();
    test_random_slip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lp_tree_deserializer.md
# lp_tree_deserializer

Serial-to-parallel receiver that is the far end of `lp_tree_serializer`'s link: it samples `SERIAL_IN` once per clock and reassembles `WIDTH`-bit words. Each completed word is presented on `PAR_OUT` with a one-cycle `VALID` strobe. Frame position comes from a free-running bit counter, not from an in-band marker. A `SLIP` input lets the integrating logic realign frame boundaries one bit at a time.

## Interface
Parameters:
- `WIDTH`, 16, word width; a power of two, at least 2.
- `MSB_FIRST`, 0, bit order on the line. 0 means bit 0 is received first; 1 means bit `WIDTH-1` is received first.
- `INIT_COUNT`, 0, reset value of the bit counter (0..`WIDTH-1`). Used to absorb serializer pipeline latency.

Ports:
- `CLK`  in  1  clock. All sampling is on the rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `SERIAL_IN`  in  1  serial data, sampled on every rising edge outside reset.
- `SLIP`  in  1  single-cycle request to shift the frame boundary by one bit.
- `PAR_OUT`  out  `WIDTH`  last completed word, registered.
- `VALID`  out  1  high for exactly one cycle per completed word.
- `VPWR`  inout  supply1  power.
- `VGND`  inout  supply0  ground.

## Operation
- State:
  - shift register `shreg[WIDTH]`
  - counter `cnt[$clog2(WIDTH)]`
  - flag `primed`
  - output registers `PAR_OUT`, `VALID`
- Reset (`RESET`=0, takes effect immediately, no clock needed):
  - `shreg`=0, `cnt`=`INIT_COUNT`, `PAR_OUT`=0, `VALID`=0
  - `primed`=1 if `INIT_COUNT`==0, else 0
- Each rising edge with `RESET`=1:
  - Shift, LSB-first (`MSB_FIRST`=0): `shreg` <= {`SERIAL_IN`, `shreg[WIDTH-1:1]`}.
  - Shift, MSB-first (`MSB_FIRST`=1): `shreg` <= {`shreg[WIDTH-2:0]`, `SERIAL_IN`}.
  - `SLIP`=1: `cnt` holds and `VALID`<=0. The shift still occurs. No word is emitted, even when `cnt`==`WIDTH-1`.
  - `SLIP`=0 and `cnt`<`WIDTH-1`: `cnt`++, `VALID`<=0.
  - `SLIP`=0 and `cnt`==`WIDTH-1`:
    - `cnt`<=0 (wrap) and `primed`<=1.
    - If `primed` was already 1: `PAR_OUT`<= the next value of `shreg` (includes the current `SERIAL_IN`) and `VALID`<=1.
    - Otherwise: `VALID`<=0 and `PAR_OUT` is unchanged. This suppresses the partial first frame when `INIT_COUNT`≠0.
- `PAR_OUT` holds its value between strobes. It is never cleared except by reset.
- `SLIP` held high for N cycles delays the boundary by N bits. `SLIP` does not clear `primed`, because the shift register always contains the last `WIDTH` bits.
- No framing check and no error output.

## Timing
- Latency: the last bit of a word is sampled at edge E. `PAR_OUT` and `VALID` update at E and are visible for the cycle after E.
- Steady state: one `VALID` every `WIDTH` cycles. Each asserted `SLIP` cycle adds 1 to that period.
- With `INIT_COUNT`=0, the first `VALID` follows the `WIDTH`-th edge after reset release.
- With `INIT_COUNT`=k≠0, the first wrap occurs on the (`WIDTH`-k)-th edge and is suppressed. The first `VALID` follows edge 2·`WIDTH`-k.
- Reset asserted mid-frame: all state clears at once and any partial word is discarded.
- Reset release counts as edge 0. The first edge with `RESET`=1 samples bit 0 of the frame.

## Structure
- Package `lp_serdes_pkg`, shared with `lp_tree_serializer`:
  - default width constant `LP_SER_WIDTH`=16
  - counter width derived from it
  - bit-order enum (`LSB_FIRST`, `MSB_FIRST`)
- One sub-module, `lp_deser_counter`: the mod-`WIDTH` counter with hold (`SLIP`) and wrap strobe, plus `primed` generation. The shift and output registers stay in the top level.

## Test plan
- Reset defaults: hold `RESET`=0 and toggle `SERIAL_IN` → `PAR_OUT`=16'h0000, `VALID`=0 throughout.
- LSB-first frame: `MSB_FIRST`=0. Drive 16'hC5AF LSB-first on 16 edges after release → `VALID` high for one cycle after edge 16, `PAR_OUT`=16'hC5AF, held until the next frame.
- MSB-first frame: `MSB_FIRST`=1. Send 16'hFF00 then 16'hF00F → `VALID` after edges 16 and 32 with those exact words.
- Partial first frame: `INIT_COUNT`=4 with a continuous 16'hCC33 stream → no `VALID` at edge 12. First `VALID` after edge 28, then every 16 edges.
- Slip: continuous LSB-first 16'h8811 stream, one-cycle `SLIP` at edge 5 → next `VALID` after edge 17. `PAR_OUT` is 16'h8811 rotated by one bit, and the period returns to 16.
- Mid-frame reset and loopback:
  - Assert `RESET` after 8 bits → `PAR_OUT`/`VALID` clear with no clock edge. Next `VALID` follows 16 edges after release.
  - Loopback with `lp_tree_serializer` sending 16'hA815 and 16'hA995 → each word received intact.
